psum_drain: RTL and testbench
=============================

# psum_drain

Drains the accumulated partial sums out of the systolic PE array once computation ends. Drives the array's FLUSH/STALL controls so the accumulator column chain shifts one row per cycle toward the bottom edge. Captures the bottom-row ACC_out vector each cycle into a small FIFO. Presents the results as row vectors on a valid/ready stream toward the write-back/output stage.

## Interface
Parameters:
- ROWS, 4: PE rows in the array; number of beats per drain.
- COLS, 4: PE columns; lanes per output beat.
- ACC_BWIDTH, 32: width of one accumulator (signed INT32).
- FIFO_DEPTH, 4: output buffer entries; must be ≥1, power of two.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- DRAIN_start  in  1  request a drain; sampled only in IDLE.
- ACC_in  in  COLS*ACC_BWIDTH  bottom-row PE ACC_out, column c at bits [c*ACC_BWIDTH +: ACC_BWIDTH].
- FLUSH  out  1  to every PE; high in DRAIN.
- STALL  out  1  to every PE; high in DRAIN while FIFO full.
- OUT_valid  out  1  head beat available.
- OUT_ready  in  1  consumer accepts head beat.
- OUT_data  out  COLS*ACC_BWIDTH  head row vector, same lane packing as ACC_in.
- OUT_last  out  1  head beat is the final (top-row) vector.
- BUSY  out  1  state ≠ IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, DRAIN, WAIT.
  - IDLE→DRAIN on DRAIN_start.
  - DRAIN→WAIT when the ROWS-th push occurs.
  - WAIT→IDLE when FIFO count==0.
- The array controller holds COMPUTE=0 while BUSY=1; this block does not drive COMPUTE. The array ties the top-row ACC_in to 0.
- push = (state==DRAIN) && (count<FIFO_DEPTH). A push writes {last = (row_cnt==ROWS-1), ACC_in} and increments row_cnt.
- FLUSH = (state==DRAIN). STALL = (state==DRAIN) && (count==FIFO_DEPTH). The array shifts exactly on push cycles, so every row is captured exactly once.
- Beat order: the first beat is the original bottom row (row ROWS-1); the last beat is row 0 and carries OUT_last=1.
- pop = OUT_valid && OUT_ready. OUT_valid = (count≠0). OUT_data/OUT_last show the head entry (show-ahead, read from registers; no combinational path from ACC_in).
- Push and pop may occur in the same cycle; count is then unchanged.
- Full: push is blocked even if a pop occurs the same cycle, which keeps OUT_ready off the STALL path.
- Pointers wrap modulo FIFO_DEPTH.
- DONE = (state==WAIT) && (count==0); it is high in the same cycle the FSM returns to IDLE.
- DRAIN_start while BUSY is ignored (not queued).
- Data is passed through bit-exact; there is no arithmetic on it.

## Timing
- Reset values: state IDLE, row_cnt 0, count 0, pointers 0. Outputs: FLUSH=0, STALL=0, OUT_valid=0, OUT_last=0, OUT_data=0, BUSY=0, DONE=0.
- RST mid-drain: next cycle all of the above; FIFO contents discarded; FLUSH drops immediately. The array content is then undefined and must be recomputed.
- Latency: DRAIN_start high in cycle 0 gives DRAIN and FLUSH=1 in cycle 1, first push at the end of cycle 1, and OUT_valid=1 in cycle 2.
- With OUT_ready held 1: pushes occur in cycles 1..ROWS, pops in cycles 2..ROWS+1, WAIT starts in cycle ROWS+1, and DONE is high in cycle ROWS+2.
- Backpressure: OUT_data/OUT_last are stable while OUT_valid && !OUT_ready.

## Structure
- Shared package (systolic_pkg): state enum {IDLE, DRAIN, WAIT}; default ACC_BWIDTH/ROWS/COLS constants shared with the PE-array top.
- Sub-module psum_fifo: synchronous show-ahead FIFO (width COLS*ACC_BWIDTH+1, depth FIFO_DEPTH) with count output. The FSM and the row counter stay in psum_drain.

## Test plan
Bench configuration: ROWS=4, COLS=2, FIFO_DEPTH=2, with a behavioural 4×2 PE flush chain.
- Preload column accumulators rows 0..3 = {1,2,3,4}/{-5,-6,-7,-8}; pulse DRAIN_start; OUT_ready=1 → beats {4,-8},{3,-7},{2,-6},{1,-5}; OUT_last only on the 4th beat; DONE in cycle 6; FLUSH high in cycles 1..4.
- Same preload, OUT_ready=0 until cycle 10 → STALL=1 from cycle 3 onward, no rows lost or duplicated, same 4 beats in order, OUT_data stable while stalled.
- OUT_ready toggling 1,0,1,0 → exactly 4 beats, correct order; count never exceeds 2.
- Extreme values: 0x7FFFFFFF and 0x80000000 pass through bit-exact.
- DRAIN_start pulsed again in cycle 2 → ignored; exactly 4 beats, one DONE.
- RST asserted in cycle 3 of a drain → next cycle FLUSH=0, OUT_valid=0, BUSY=0; a new drain afterwards produces 4 beats.

Source files
------------

// File: rtl/systolic_pkg.sv
// Definitions shared by the systolic PE array and its drain/write-back logic.
package systolic_pkg;

    localparam int unsigned DEF_ROWS       = 4;
    localparam int unsigned DEF_COLS       = 4;
    localparam int unsigned DEF_ACC_BWIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } drain_state_e;

    // Index width that stays at least one bit for single-entry structures.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_drain_if.sv
// Valid/ready row-vector stream from the partial-sum drain to write-back.
interface psum_drain_if
    import systolic_pkg::*;
#(
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ACC_BWIDTH = DEF_ACC_BWIDTH
);
    logic                       OUT_valid;
    logic                       OUT_ready;
    logic [COLS*ACC_BWIDTH-1:0] OUT_data;
    logic                       OUT_last;

    modport master (output OUT_valid, output OUT_data, output OUT_last, input  OUT_ready);
    modport slave  (input  OUT_valid, input  OUT_data, input  OUT_last, output OUT_ready);
endinterface

// File: rtl/psum_drain_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head reads as zero when empty.
module psum_fifo
    import systolic_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_COLS*DEF_ACC_BWIDTH + 1,
    parameter  int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned PTR_W = idx_w(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset, so the head is masked to keep outputs clean after reset.
    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/psum_drain.sv
// Shifts accumulated partial sums out of the PE array bottom row and streams them as row vectors.
module psum_drain
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS       = DEF_ROWS,
    parameter int unsigned COLS       = DEF_COLS,
    parameter int unsigned ACC_BWIDTH = DEF_ACC_BWIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
)(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       DRAIN_start,
    input  logic [COLS*ACC_BWIDTH-1:0] ACC_in,
    output logic                       FLUSH,
    output logic                       STALL,
    psum_drain_if.master               out_if,
    output logic                       BUSY,
    output logic                       DONE
);
    localparam int unsigned DW    = COLS*ACC_BWIDTH;
    localparam int unsigned ROW_W = idx_w(ROWS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    drain_state_e     state_q, state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] count;
    logic [DW:0]      fifo_rdata;
    logic             push, pop, full, empty, last_row;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign last_row = (row_cnt_q == ROW_W'(ROWS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        push      = 1'b0;
        FLUSH     = 1'b0;
        STALL     = 1'b0;
        DONE      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (DRAIN_start) begin
                    state_d   = DRAIN;
                    row_cnt_d = '0;
                end
            end
            DRAIN: begin
                // Full blocks the push regardless of a same-cycle pop, keeping OUT_ready off STALL.
                FLUSH = 1'b1;
                STALL = full;
                push  = !full;
                if (push) begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    if (last_row) begin
                        state_d   = WAIT;
                        row_cnt_d = '0;
                    end
                end
            end
            WAIT: begin
                if (empty) begin
                    DONE    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY = (state_q != IDLE);

    psum_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({last_row, ACC_in}),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    assign out_if.OUT_valid = !empty;
    assign pop              = out_if.OUT_valid && out_if.OUT_ready;
    assign out_if.OUT_last  = fifo_rdata[DW];
    assign out_if.OUT_data  = fifo_rdata[DW-1:0];
endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain driving a behavioural 4x2 PE flush chain.
module tb_psum_drain;
    import systolic_pkg::*;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              DRAIN_start;
    logic [COLS*AW-1:0] ACC_in;
    logic              FLUSH, STALL, BUSY, DONE;

    psum_drain_if #(.COLS(COLS), .ACC_BWIDTH(AW)) bus ();

    psum_drain #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .ACC_BWIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .DRAIN_start (DRAIN_start),
        .ACC_in      (ACC_in),
        .FLUSH       (FLUSH),
        .STALL       (STALL),
        .out_if      (bus.master),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic               last;
        logic [COLS*AW-1:0] data;
    } beat_t;

    beat_t       sb_q[$];
    beat_t       exp_b, held;
    logic        hold_q = 1'b0;
    int          checks = 0, passes = 0, beats = 0, occ = 0;
    logic [AW-1:0] arr [ROWS][COLS];
    logic [AW-1:0] pre [ROWS][COLS];
    logic        load;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Column accumulator chain: shifts one row toward the bottom on every push cycle.
    always @(posedge CLK) begin
        if (load) begin
            arr <= pre;
        end else if (FLUSH && !STALL) begin
            for (int r = ROWS - 1; r > 0; r--) arr[r] <= arr[r-1];
            for (int c = 0; c < COLS; c++) arr[0][c] <= '0;
        end
    end
    assign ACC_in = {arr[ROWS-1][1], arr[ROWS-1][0]};

    always @(negedge CLK) begin
        if (RST) begin
            occ    = 0;
            hold_q = 1'b0;
        end else begin
            check("valid_vs_occ", bus.OUT_valid, occ != 0);
            check("stall_vs_full", STALL, FLUSH && (occ == DEPTH));
            if (hold_q) begin
                check("hold_data", bus.OUT_data, held.data);
                check("hold_last", bus.OUT_last, held.last);
            end
            if (bus.OUT_valid && bus.OUT_ready) begin
                beats++;
                if (sb_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp_b = sb_q.pop_front();
                    check("beat_data", bus.OUT_data, exp_b.data);
                    check("beat_last", bus.OUT_last, exp_b.last);
                end
            end
            occ = occ + ((FLUSH && !STALL) ? 1 : 0) - ((bus.OUT_valid && bus.OUT_ready) ? 1 : 0);
            check("occ_max", occ <= DEPTH, 1);
            hold_q = bus.OUT_valid && !bus.OUT_ready;
            held   = '{last: bus.OUT_last, data: bus.OUT_data};
        end
    end

    task automatic preload(input logic [ROWS*AW-1:0] c0, input logic [ROWS*AW-1:0] c1);
        for (int r = 0; r < ROWS; r++) begin
            pre[r][0] = c0[r*AW +: AW];
            pre[r][1] = c1[r*AW +: AW];
        end
        load = 1'b1;
        @(posedge CLK); #1;
        load = 1'b0;
    endtask

    task automatic expect_beat(input logic [AW-1:0] col1, input logic [AW-1:0] col0, input logic last);
        sb_q.push_back('{last: last, data: {col1, col0}});
    endtask

    // Rows 0..3 = {1,2,3,4} / {-5,-6,-7,-8}, drained bottom row first.
    task automatic setup_std();
        preload({32'd4, 32'd3, 32'd2, 32'd1},
                {32'hFFFF_FFF8, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFB});
        expect_beat(32'hFFFF_FFF8, 32'd4, 1'b0);
        expect_beat(32'hFFFF_FFF9, 32'd3, 1'b0);
        expect_beat(32'hFFFF_FFFA, 32'd2, 1'b0);
        expect_beat(32'hFFFF_FFFB, 32'd1, 1'b1);
    endtask

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            1:       return k >= 10;
            2:       return (k % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // Called at cycle 0 (just after a rising edge); k counts cycles after DRAIN_start.
    task automatic drain(input int mode, input int restart, input int fl_hi,
                         input int st_lo, input int st_hi, input int done_c);
        int dones = 0;
        int b0    = beats;
        DRAIN_start   = 1'b1;
        bus.OUT_ready = rdy(mode, 0);
        @(negedge CLK);
        check("busy_c0", BUSY, 0);
        check("flush_c0", FLUSH, 0);
        for (int k = 1; k <= 18; k++) begin
            @(posedge CLK); #1;
            DRAIN_start   = (k == restart);
            bus.OUT_ready = rdy(mode, k);
            @(negedge CLK);
            check("flush", FLUSH, k <= fl_hi);
            check("stall", STALL, (k >= st_lo) && (k <= st_hi));
            check("done", DONE, k == done_c);
            check("busy", BUSY, k <= done_c);
            if (DONE) dones++;
        end
        @(posedge CLK); #1;
        DRAIN_start = 1'b0;
        check("done_count", dones, 1);
        check("beat_count", beats - b0, 4);
        check("sb_drained", sb_q.size(), 0);
    endtask

    initial begin
        RST           = 1'b1;
        DRAIN_start   = 1'b0;
        bus.OUT_ready = 1'b0;
        load          = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_flush", FLUSH, 0);
        check("rst_stall", STALL, 0);
        check("rst_valid", bus.OUT_valid, 0);
        check("rst_last", bus.OUT_last, 0);
        check("rst_data", bus.OUT_data, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Free-flowing drain.
        setup_std();
        drain(0, -1, 4, 99, 0, 6);

        // Consumer blocked until cycle 10.
        setup_std();
        drain(1, -1, 12, 3, 10, 14);

        // Consumer ready on alternate cycles.
        setup_std();
        drain(2, -1, 5, 4, 4, 9);

        // Signed extremes pass through untouched.
        preload({32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF},
                {32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000});
        expect_beat(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        expect_beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        expect_beat(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        expect_beat(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        drain(0, -1, 4, 99, 0, 6);

        // Second DRAIN_start while busy is ignored.
        setup_std();
        drain(0, 2, 4, 99, 0, 6);

        // Reset in cycle 3 of a blocked drain, then a clean drain.
        setup_std();
        DRAIN_start   = 1'b1;
        bus.OUT_ready = 1'b0;
        @(posedge CLK); #1;
        DRAIN_start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("pre_rst_stall", STALL, 1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_flush", FLUSH, 0);
        check("midrst_stall", STALL, 0);
        check("midrst_valid", bus.OUT_valid, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        check("midrst_data", bus.OUT_data, 0);
        sb_q.delete();
        @(posedge CLK); #1;
        setup_std();
        drain(0, -1, 4, 99, 0, 6);

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
